sync_fifo_ext: RTL and testbench

Parametrised single-clock FIFO. It is the next generation of the team's 8-bit × 16 synchronous FIFO and keeps the same core port set (clk, rst, wdata, w_en, r_en, rdata, wfull, rempty). New features:
- generic data width and depth;
- occupancy count;
- programmable almost-full and almost-empty flags;
- registered overflow and underflow error pulses;
- synchronous flush;
- build-time first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_ext.sv | 91 +++++++++
 tb/tb_sync_fifo_ext.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error pulses, flush and build-time FWFT.
// Standard reads land on rdata one cycle after r_en; writes are refused while full and flagged with a one-cycle overflow pulse.
module sync_fifo_ext #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int AF_LEVEL = (1 << ADDRSIZE) - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                w_en,
  input  logic                r_en,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE + 1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AF_C    = (ADDRSIZE + 1)'(AF_LEVEL);
  localparam logic [ADDRSIZE:0] AE_C    = (ADDRSIZE + 1)'(AE_LEVEL);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE-1:0] wptr;
  logic [ADDRSIZE-1:0] rptr;
  logic                w_acc;
  logic                r_acc;

  // Flags come straight from the count register, so they only move on clk.
  assign wfull        = (count == DEPTH_C);
  assign rempty       = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign w_acc = w_en && !wfull && !clr;
  assign r_acc = r_en && !rempty && !clr;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (r_acc) rptr <= rptr + 1'b1;
      case ({w_acc, r_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= w_en && wfull;
      underflow <= r_en && rempty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is exposed directly; an empty FIFO presents zero.
      assign rdata = rempty ? '0 : mem[rptr];
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata <= '0;
        end else if (r_acc) begin
          rdata <= mem[rptr];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: standard and FWFT builds share stimulus and are checked against a queue model.
module tb_sync_fifo_ext;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;

  logic [7:0] rdata_s, rdata_f;
  logic       wfull_s, wfull_f, rempty_s, rempty_f;
  logic       af_s, af_f, ae_s, ae_f;
  logic [4:0] count_s, count_f;
  logic       ovf_s, ovf_f, unf_s, unf_f;

  sync_fifo_ext #(.DATASIZE(8), .ADDRSIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .w_en(w_en), .r_en(r_en),
    .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s));

  sync_fifo_ext #(.DATASIZE(8), .ADDRSIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .w_en(w_en), .r_en(r_en),
    .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a queue, plus the standard-mode output register and error pulses.
  logic [7:0] q[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_rdata = 8'h00;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endfunction

  function automatic void model_step(logic w, logic r, logic [7:0] d, logic c);
    int n;
    n = q.size();
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = w && (n == 16);
      m_unf = r && (n == 0);
      if (r && n != 0) m_rdata = q.pop_front();
      if (w && n != 16) q.push_back(d);
    end
  endfunction

  // One clock: drive, take the edge, advance the model, return just after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    w_en  = w;
    r_en  = r;
    wdata = d;
    clr   = c;
    @(posedge clk);
    if (!rst) model_step(w, r, d, c);
    #1;
  endtask

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count",        count_s,  n);
    chk("count_f",      count_f,  n);
    chk("rempty",       rempty_s, n == 0);
    chk("rempty_f",     rempty_f, n == 0);
    chk("wfull",        wfull_s,  n == 16);
    chk("wfull_f",      wfull_f,  n == 16);
    chk("almost_full",  af_s,     n >= 14);
    chk("almost_empty", ae_s,     n <= 2);
    chk("almost_f",     {af_f, ae_f}, {n >= 14, n <= 2});
    chk("overflow",     {ovf_s, ovf_f}, {m_ovf, m_ovf});
    chk("underflow",    {unf_s, unf_f}, {m_unf, m_unf});
    chk("rdata",        rdata_s,  m_rdata);
    chk("rdata_f",      rdata_f,  (n != 0) ? q[0] : 8'h00);
  end

  initial begin
    logic [7:0] v;
    model_reset();

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_count", count_s, 0);
    chk("rst_flags", {rempty_s, wfull_s, ae_s, af_s, ovf_s, unf_s}, 6'b101000);
    chk("rst_rdata", rdata_s, 8'h00);
    rst = 1'b0;

    // Fill with 0..16; the 17th write must be dropped
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 1)  chk("ae_at2", ae_s, 1'b1);
      if (i == 2)  chk("ae_at3", ae_s, 1'b0);
      if (i == 12) chk("af_at13", af_s, 1'b0);
      if (i == 13) chk("af_at14", af_s, 1'b1);
      if (i == 14) chk("wfull_at15", wfull_s, 1'b0);
      if (i == 15) chk("wfull_at16", {wfull_s, ovf_s}, 2'b10);
      if (i == 16) chk("ovf_pulse", {ovf_s, count_s}, {1'b1, 5'd16});
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_once", ovf_s, 1'b0);

    // Drain 17 times
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      if (i < 16) chk("drain_rdata", rdata_s, i);
      else        chk("drain_unf", {unf_s, rdata_s, rempty_s, count_s}, {1'b1, 8'd15, 1'b1, 5'd0});
    end

    // Simultaneous when full
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    chk("full_both", {count_s, ovf_s, rdata_s}, {5'd15, 1'b1, 8'h10});
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // Simultaneous when empty
    cyc(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("empty_both", {count_s, unf_s}, {5'd1, 1'b1});
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("empty_both_rd", rdata_s, 8'hA5);

    // Wrap: 5 x (10 writes, 10 reads)
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(k * 10 + i), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("wrap_last", rdata_s, 8'd49);

    // Random traffic with occasional flush
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom % 2), 1'($urandom % 2), 8'($urandom), 1'(($urandom % 64) == 0));

    // clr with a concurrent write
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    chk("pre_clr_count", count_s, 7);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("clr_state", {count_s, rempty_s}, {5'd0, 1'b1});
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("clr_not_stored", rdata_s, 8'h5A);

    // Async reset between edges
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_count", {count_s, count_f}, 10'd0);
    chk("arst_flags", {rempty_s, wfull_s, ae_s, af_s, ovf_s, unf_s}, 6'b101000);
    chk("arst_rdata", {rdata_s, rdata_f}, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // FWFT behaviour
    cyc(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("fwft_first", {rdata_f, rempty_f}, {8'h3C, 1'b0});
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_pop", {rdata_f, rempty_f}, {8'h00, 1'b1});
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      v = rdata_f;
      chk("fwft_head", v, i);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("fwft_drained", {rdata_f, rempty_f}, {8'h00, 1'b1});

    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
